// File: rtl/sargantana_icache_pkg.sv
// Shared types and constants for the icache line-fill path.
//   ifill_state_t : fill FSM encoding (IDLE, REQ, WAIT_DATA, RESP)
//   ICACHE_*      : default geometry of an icache line and of a memory beat
//   ifill_req_t   : fill request payload (physical address)
//   ifill_resp_t  : fill response payload (line data, error)
//   line_align()  : clears the byte-offset-within-line bits of an address
package sargantana_icache_pkg;

  localparam int ICACHE_PADDR_WIDTH = 40;
  localparam int ICACHE_LINE_WIDTH  = 256;
  localparam int ICACHE_BEAT_WIDTH  = 64;
  localparam int ICACHE_N_BEATS     = ICACHE_LINE_WIDTH / ICACHE_BEAT_WIDTH;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DATA = 2'd2,
    RESP      = 2'd3
  } ifill_state_t;

  typedef struct packed {
    logic [ICACHE_PADDR_WIDTH-1:0] paddr;
  } ifill_req_t;

  typedef struct packed {
    logic [ICACHE_LINE_WIDTH-1:0] data;
    logic                         err;
  } ifill_resp_t;

  localparam int ICACHE_LINE_OFFSET = $clog2(ICACHE_LINE_WIDTH / 8);

  function automatic logic [ICACHE_PADDR_WIDTH-1:0] line_align(
    input logic [ICACHE_PADDR_WIDTH-1:0] addr
  );
    logic [ICACHE_PADDR_WIDTH-1:0] res;
    res = addr;
    res[ICACHE_LINE_OFFSET-1:0] = '0;
    return res;
  endfunction

endpackage

// File: rtl/sargantana_icache_ifill_unit_if.sv
// Bundle of every handshake/bus signal around the ifill unit.
//   Controller side : ifill_req_*, ifill_kill_i, ifill_sent_ack_o,
//                     ifill_resp_*, valid_ifill_resp_o
//   Memory side     : mem_req_* (read request), mem_resp_* (beats)
// modport slave  : the ifill unit itself
// modport master : the environment (icache controller + next memory level)
//
// Handshake rules: a request transfers on a cycle where valid and ready are
// both high at the clock edge; once valid is raised it stays high with a
// stable payload until that edge. mem_resp_valid_i has no ready: every beat
// presented while the unit waits for data is consumed in that cycle.
interface sargantana_icache_ifill_unit_if
  import sargantana_icache_pkg::*;
#(
  parameter int PADDR_WIDTH = ICACHE_PADDR_WIDTH,
  parameter int LINE_WIDTH  = ICACHE_LINE_WIDTH,
  parameter int BEAT_WIDTH  = ICACHE_BEAT_WIDTH
) ();

  logic                   ifill_req_valid_i;
  logic [PADDR_WIDTH-1:0] ifill_req_paddr_i;
  logic                   ifill_req_ready_o;
  logic                   ifill_kill_i;
  logic                   ifill_sent_ack_o;
  logic                   ifill_resp_valid_o;
  logic                   valid_ifill_resp_o;
  logic [LINE_WIDTH-1:0]  ifill_resp_data_o;
  logic                   ifill_resp_err_o;
  logic                   mem_req_valid_o;
  logic                   mem_req_ready_i;
  logic [PADDR_WIDTH-1:0] mem_req_addr_o;
  logic                   mem_resp_valid_i;
  logic [BEAT_WIDTH-1:0]  mem_resp_data_i;
  logic                   mem_resp_err_i;

  modport slave (
    input  ifill_req_valid_i, ifill_req_paddr_i, ifill_kill_i,
    input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i, mem_resp_err_i,
    output ifill_req_ready_o, ifill_sent_ack_o, ifill_resp_valid_o,
    output valid_ifill_resp_o, ifill_resp_data_o, ifill_resp_err_o,
    output mem_req_valid_o, mem_req_addr_o
  );

  modport master (
    output ifill_req_valid_i, ifill_req_paddr_i, ifill_kill_i,
    output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i, mem_resp_err_i,
    input  ifill_req_ready_o, ifill_sent_ack_o, ifill_resp_valid_o,
    input  valid_ifill_resp_o, ifill_resp_data_o, ifill_resp_err_o,
    input  mem_req_valid_o, mem_req_addr_o
  );

endinterface

// File: rtl/sargantana_icache_line_assembler.sv
// Collects memory beats into one icache line.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear        : start of a new fill; zeroes beat counter and error flag
//   beat_valid   : a beat is consumed this cycle
//   beat_data    : beat payload, placed at slot beat_cnt (lowest beat first)
//   beat_err     : beat error, ORed into err
//   line_next    : line buffer with the current beat already merged in
//   err          : sticky OR of all beat errors since clear
//   last_beat    : the beat consumed this cycle completes the line
module sargantana_icache_line_assembler #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear,
  input  logic                  beat_valid,
  input  logic [BEAT_WIDTH-1:0] beat_data,
  input  logic                  beat_err,
  output logic [LINE_WIDTH-1:0] line_next,
  output logic                  err,
  output logic                  last_beat
);

  localparam int N_BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BEATS - 1);

  logic [CNT_W-1:0]      beat_cnt;
  logic [LINE_WIDTH-1:0] line_q;
  logic                  err_q;

  assign last_beat = beat_valid && (beat_cnt == LAST_CNT);
  assign err       = err_q;

  // Merged view lets the top capture the complete line on the last-beat edge.
  always_comb begin
    line_next = line_q;
    if (beat_valid) begin
      line_next[beat_cnt*BEAT_WIDTH +: BEAT_WIDTH] = beat_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt <= '0;
      line_q   <= '0;
      err_q    <= 1'b0;
    end else if (clear) begin
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else if (beat_valid) begin
      line_q   <= line_next;
      err_q    <= err_q | beat_err;
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sargantana_icache_ifill_unit.sv
// Responder end of the icache IFILL interface. Accepts one fill request,
// issues one line-aligned read to memory, assembles the returned beats and
// answers with a one-cycle response pulse. A kill lets the fill run to its
// last beat silently so memory is quiescent when ifill_sent_ack_o drops.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : controller and memory handshakes (slave modport)
//   dbg_state    : current FSM state
// Module parameters must match those of the connected interface instance;
// LINE_WIDTH must be a multiple of BEAT_WIDTH.
module sargantana_icache_ifill_unit
  import sargantana_icache_pkg::*;
#(
  parameter int PADDR_WIDTH = ICACHE_PADDR_WIDTH,
  parameter int LINE_WIDTH  = ICACHE_LINE_WIDTH,
  parameter int BEAT_WIDTH  = ICACHE_BEAT_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  sargantana_icache_ifill_unit_if.slave bus,
  output ifill_state_t                  dbg_state
);

  localparam int LINE_OFFSET = $clog2(LINE_WIDTH / 8);

  ifill_state_t           state_q, state_d;
  logic                   killed_q;
  logic [PADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0]  resp_data_q;

  logic                   accept;
  logic                   kill_now;
  logic                   beat_fire;
  logic                   last_beat;
  logic                   asm_err;
  logic [LINE_WIDTH-1:0]  line_next;
  logic [PADDR_WIDTH-1:0] aligned_addr;

  assign accept    = (state_q == IDLE) && bus.ifill_req_valid_i;
  assign kill_now  = bus.ifill_kill_i && ((state_q == REQ) || (state_q == WAIT_DATA));
  // Beats arriving in any other state are protocol violations and dropped.
  assign beat_fire = (state_q == WAIT_DATA) && bus.mem_resp_valid_i;

  always_comb begin
    aligned_addr = bus.ifill_req_paddr_i;
    aligned_addr[LINE_OFFSET-1:0] = '0;
  end

  sargantana_icache_line_assembler #(
    .LINE_WIDTH (LINE_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_line_assembler (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear      (accept),
    .beat_valid (beat_fire),
    .beat_data  (bus.mem_resp_data_i),
    .beat_err   (bus.mem_resp_err_i),
    .line_next  (line_next),
    .err        (asm_err),
    .last_beat  (last_beat)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.ifill_req_valid_i) state_d = REQ;
      REQ:       if (bus.mem_req_ready_i) state_d = WAIT_DATA;
      // A kill arriving together with the last beat still suppresses RESP.
      WAIT_DATA: if (last_beat) state_d = (killed_q || bus.ifill_kill_i) ? IDLE : RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      killed_q    <= 1'b0;
      addr_q      <= '0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= aligned_addr;
        killed_q <= 1'b0;
      end else if (kill_now) begin
        killed_q <= 1'b1;
      end
      // Output line only updates for fills that will respond, so the data
      // seen by the cache holds steady between responses.
      if (last_beat && !killed_q && !bus.ifill_kill_i) begin
        resp_data_q <= line_next;
      end
    end
  end

  assign bus.ifill_req_ready_o  = (state_q == IDLE);
  assign bus.ifill_sent_ack_o   = (state_q == REQ) || (state_q == WAIT_DATA);
  assign bus.ifill_resp_valid_o = (state_q == RESP);
  assign bus.valid_ifill_resp_o = (state_q == RESP);
  assign bus.ifill_resp_data_o  = resp_data_q;
  assign bus.ifill_resp_err_o   = (state_q == RESP) && asm_err;
  assign bus.mem_req_valid_o    = (state_q == REQ);
  assign bus.mem_req_addr_o     = addr_q;
  assign dbg_state              = state_q;

  a_no_stray_beat : assert property (
    @(posedge clk_i) disable iff (rst_i)
    bus.mem_resp_valid_i |-> (state_q == WAIT_DATA)
  );

endmodule

// File: tb/tb_sargantana_icache_ifill_unit.sv
module tb_sargantana_icache_ifill_unit;
  import sargantana_icache_pkg::*;

  localparam int PW = 40;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int NB = LW / BW;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  sargantana_icache_ifill_unit_if #(.PADDR_WIDTH(PW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW)) bus ();
  ifill_state_t dbg_state;

  sargantana_icache_ifill_unit #(.PADDR_WIDTH(PW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  int resp_cnt = 0;
  logic [LW:0] exp_q[$];          // {err, line}
  logic [BW-1:0] beat_tab[NB];
  logic [LW-1:0] last_line;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, sample 1 ns after the edge, and score any response.
  task automatic tick();
    logic [LW:0] e;
    @(posedge clk_i);
    #1;
    if (bus.ifill_resp_valid_o === 1'b1) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_resp", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("resp_data", bus.ifill_resp_data_o, e[LW-1:0]);
        check("resp_err", LW'(bus.ifill_resp_err_o), LW'(e[LW]));
        check("resp_valid_pair", LW'(bus.valid_ifill_resp_o), 1);
        last_line = e[LW-1:0];
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic fill(input logic [PW-1:0] paddr, input logic [PW-1:0] exp_addr,
                      input int req_wait, input int kill_req_cyc, input int gap,
                      input int kill_beat, input logic [NB-1:0] errs);
    logic killed;
    logic [LW-1:0] line;
    killed = 1'b0;
    for (int i = 0; i < NB; i++) line[i*BW +: BW] = beat_tab[i];

    bus.ifill_req_valid_i = 1'b1;
    bus.ifill_req_paddr_i = paddr;
    tick();
    bus.ifill_req_valid_i = 1'b0;
    check("req_state", LW'(dbg_state), LW'(REQ));
    check("req_valid", LW'(bus.mem_req_valid_o), 1);
    check("req_addr", LW'(bus.mem_req_addr_o), LW'(exp_addr));
    check("req_sent_ack", LW'(bus.ifill_sent_ack_o), 1);
    check("req_not_ready", LW'(bus.ifill_req_ready_o), 0);

    for (int c = 0; c < req_wait; c++) begin
      bus.mem_req_ready_i = 1'b0;
      if (c == kill_req_cyc) begin
        bus.ifill_kill_i = 1'b1;
        killed = 1'b1;
      end
      tick();
      bus.ifill_kill_i = 1'b0;
      check("bp_valid_held", LW'(bus.mem_req_valid_o), 1);
      check("bp_addr_held", LW'(bus.mem_req_addr_o), LW'(exp_addr));
    end
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    check("wait_state", LW'(dbg_state), LW'(WAIT_DATA));
    check("wait_req_dropped", LW'(bus.mem_req_valid_o), 0);

    for (int b = 0; b < NB; b++) begin
      for (int g = 0; g < gap; g++) tick();
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_resp_data_i  = beat_tab[b];
      bus.mem_resp_err_i   = errs[b];
      if (b == kill_beat) begin
        bus.ifill_kill_i = 1'b1;
        killed = 1'b1;
      end
      if (b == NB - 1 && !killed) exp_q.push_back({|errs, line});
      tick();
      bus.mem_resp_valid_i = 1'b0;
      bus.mem_resp_err_i   = 1'b0;
      bus.ifill_kill_i     = 1'b0;
      if (b < NB - 1) check("beat_sent_ack", LW'(bus.ifill_sent_ack_o), 1);
    end

    check("after_last_sent_ack", LW'(bus.ifill_sent_ack_o), 0);
    if (killed) begin
      check("killed_idle", LW'(dbg_state), LW'(IDLE));
      check("killed_ready", LW'(bus.ifill_req_ready_o), 1);
      check("killed_no_resp", LW'(bus.ifill_resp_valid_o), 0);
      check("killed_no_replay", LW'(bus.valid_ifill_resp_o), 0);
    end else begin
      check("resp_state", LW'(dbg_state), LW'(RESP));
      check("resp_not_ready", LW'(bus.ifill_req_ready_o), 0);
      bus.ifill_kill_i = 1'b1;   // ignored once the response is committed
      tick();
      bus.ifill_kill_i = 1'b0;
      check("post_resp_idle", LW'(dbg_state), LW'(IDLE));
      check("post_resp_ready", LW'(bus.ifill_req_ready_o), 1);
      check("resp_one_cycle", LW'(bus.ifill_resp_valid_o), 0);
      check("data_held", bus.ifill_resp_data_o, line);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.ifill_req_valid_i = 1'b0;
    bus.ifill_req_paddr_i = '0;
    bus.ifill_kill_i      = 1'b0;
    bus.mem_req_ready_i   = 1'b0;
    bus.mem_resp_valid_i  = 1'b0;
    bus.mem_resp_data_i   = '0;
    bus.mem_resp_err_i    = 1'b0;
    last_line = '0;

    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    tick();
    check("rst_state", LW'(dbg_state), LW'(IDLE));
    check("rst_ready", LW'(bus.ifill_req_ready_o), 1);
    check("rst_sent_ack", LW'(bus.ifill_sent_ack_o), 0);
    check("rst_mem_valid", LW'(bus.mem_req_valid_o), 0);
    check("rst_resp_valid", LW'(bus.ifill_resp_valid_o), 0);
    check("rst_data", bus.ifill_resp_data_o, 0);

    // Basic fill, zero-wait memory.
    beat_tab[0] = 64'h1111111111111111; beat_tab[1] = 64'h2222222222222222;
    beat_tab[2] = 64'h3333333333333333; beat_tab[3] = 64'h4444444444444444;
    fill(40'h0080001234, 40'h0080001220, 0, -1, 0, -1, 4'b0000);

    // Backpressure with kill in the second stalled cycle.
    beat_tab[0] = 64'hA0A0A0A0A0A0A0A0; beat_tab[1] = 64'hA1A1A1A1A1A1A1A1;
    beat_tab[2] = 64'hA2A2A2A2A2A2A2A2; beat_tab[3] = 64'hA3A3A3A3A3A3A3A3;
    fill(40'h00ABCDE0F0, 40'h00ABCDE0E0, 5, 1, 0, -1, 4'b0000);

    // Kill on the second beat.
    fill(40'h0000000FFF, 40'h0000000FE0, 0, -1, 0, 1, 4'b0000);

    // Kill together with the last beat, then a clean fill responds.
    fill(40'h0000000FFF, 40'h0000000FE0, 0, -1, 0, 3, 4'b0000);
    beat_tab[0] = 64'h0123456789ABCDEF; beat_tab[1] = 64'hFEDCBA9876543210;
    beat_tab[2] = 64'h5555AAAA5555AAAA; beat_tab[3] = 64'hDEADBEEFCAFEF00D;
    fill(40'hFFFFFFFFFF, 40'hFFFFFFFFE0, 1, -1, 0, -1, 4'b0000);

    // Gapped beats, third beat flagged with an error.
    beat_tab[0] = 64'h00000000000000B0; beat_tab[1] = 64'h00000000000000B1;
    beat_tab[2] = 64'h00000000000000B2; beat_tab[3] = 64'h00000000000000B3;
    fill(40'h0040000040, 40'h0040000040, 0, -1, 3, -1, 4'b0100);

    // Reset in the middle of the data phase.
    bus.ifill_req_valid_i = 1'b1;
    bus.ifill_req_paddr_i = 40'h123456789F;
    tick();
    bus.ifill_req_valid_i = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    tick();
    bus.mem_req_ready_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.mem_resp_valid_i = 1'b1;
      bus.mem_resp_data_i  = 64'hEEEEEEEEEEEEEEEE;
      tick();
    end
    bus.mem_resp_valid_i = 1'b0;
    check("mid_wait_state", LW'(dbg_state), LW'(WAIT_DATA));
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_state", LW'(dbg_state), LW'(IDLE));
    check("async_rst_ready", LW'(bus.ifill_req_ready_o), 1);
    check("async_rst_sent_ack", LW'(bus.ifill_sent_ack_o), 0);
    check("async_rst_data", bus.ifill_resp_data_o, 0);
    tick();
    rst_i = 1'b0;
    tick();

    // Fresh fill after reset must start from beat slot 0.
    beat_tab[0] = 64'hC0C0C0C0C0C0C0C0; beat_tab[1] = 64'hC1C1C1C1C1C1C1C1;
    beat_tab[2] = 64'hC2C2C2C2C2C2C2C2; beat_tab[3] = 64'hC3C3C3C3C3C3C3C3;
    fill(40'h123456789F, 40'h1234567880, 0, -1, 0, -1, 4'b0000);

    repeat (3) tick();
    check("exp_q_drained", LW'(exp_q.size()), 0);
    check("resp_count", LW'(resp_cnt), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
